uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one UART_TX frame payload.
REQ-002 Parameter TMO_CYCLES, default 4, cycles allowed for TX_BUSY to rise after an issue.
REQ-003 CLK  input  1  single system clock; all state on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 ALU_OUT  input  2*DATA_WIDTH  ALU result word to transmit.
REQ-006 ALU_VLD  input  1  ALU_OUT valid; accepted when ALU_VLD & ALU_RDY.
REQ-007 ALU_RDY  output  1  ALU holding buffer empty.
REQ-008 RF_RD_DATA  input  DATA_WIDTH  register-file read data to transmit.
REQ-009 RF_RD_VLD  input  1  RF_RD_DATA valid; accepted when RF_RD_VLD & RF_RDY.
REQ-010 RF_RDY  output  1  RF holding buffer empty.
REQ-011 TX_BUSY  input  1  BUSY from the UART transmitter.
REQ-012 TX_P_DATA  output  DATA_WIDTH  byte presented to transmitter P_DATA.
REQ-013 TX_D_VLD  output  1  one-cycle DATA_VALID pulse to transmitter.
REQ-014 TMO_ERR  output  1  one-cycle pulse: TX_BUSY failed to rise within TMO_CYCLES.
REQ-015 SCHED_BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL hold one ALU buffer (2*DATA_WIDTH + pend flag) and one RF buffer (DATA_WIDTH + pend flag); ALU_RDY = !alu_pend, RF_RDY = !rf_pend.
REQ-017 An accepted request SHALL set its pend flag and capture data on the same edge; both sources may be accepted in the same cycle.
REQ-018 A pend flag SHALL clear only when its last byte completes (TX_BUSY falls), so RDY stays low for the whole transfer.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-020 IDLE: if any pend set and TX_BUSY=0, grant a source and go to ISSUE; if TX_BUSY=1, stay IDLE without issuing.
REQ-021 Arbitration SHALL be 2-way round-robin: when both pend, grant the source not granted last; last-grant pointer updates on transfer completion only.
REQ-022 ISSUE (exactly one cycle): TX_D_VLD=1, TX_P_DATA=selected byte; next state WAIT_HI.
REQ-023 ALU transfers SHALL send ALU_OUT[DATA_WIDTH-1:0] first, then ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH]; RF transfers send one byte.
REQ-024 WAIT_HI: on TX_BUSY=1 go to WAIT_LO; after TMO_CYCLES cycles without it, pulse TMO_ERR and return to ISSUE with the same byte.
REQ-025 WAIT_LO: on TX_BUSY=0, if ALU byte 0 just finished, set byte index to 1 and go to ISSUE; otherwise clear granted pend, update pointer, go to IDLE.
REQ-026 TX_P_DATA SHALL be registered and hold its value outside ISSUE; TX_D_VLD SHALL never be high two consecutive cycles.
REQ-027 Minimum spacing: grant in IDLE to TX_D_VLD is 1 cycle; back-to-back ALU bytes have no IDLE cycle between them.

Reset
REQ-028 RST low SHALL immediately force: state IDLE, both pend 0, byte index 0, timeout counter 0, last-grant pointer = RF (ALU wins first tie), TX_P_DATA 0, TX_D_VLD 0, TMO_ERR 0, SCHED_BUSY 0; ALU_RDY and RF_RDY 1.
REQ-029 Reset mid-transfer SHALL discard the in-flight request and both buffers; no retry after reset release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the source enum (SRC_ALU, SRC_RF) and the TMO_CYCLES default.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arb2 (two requests, pointer input, one-hot grant output).

Verification
REQ-032 RF_RD_VLD with 0xA5, TX_BUSY model rises 1 cycle after TX_D_VLD, falls 10 later -> one TX_D_VLD pulse, TX_P_DATA=0xA5, RF_RDY low until BUSY falls.
REQ-033 ALU_VLD with 0x1234 -> two pulses, bytes 0x34 then 0x12, second pulse the cycle after BUSY falls, ALU_RDY high afterwards.
REQ-034 ALU 0xBEEF and RF 0x5A accepted same cycle from reset -> order 0xEF, 0xBE, 0x5A; repeat with both pend again -> RF served first.
REQ-035 TX_BUSY held low after ISSUE -> TMO_ERR pulse after 4 cycles, reissue with identical TX_P_DATA.
REQ-036 RST asserted during WAIT_LO of ALU byte 0 -> all outputs at reset values asynchronously, no high byte sent after release.
REQ-037 TX_BUSY high while request pending in IDLE -> no TX_D_VLD until TX_BUSY low.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// The scheduler drains two holding buffers (ALU result word, register-file
// read byte) into a single byte-wide UART transmitter.
package uart_tx_sched_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TMO_CYCLES_DEF = 4;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } sched_state_e;

  // Transfer sources. Bit position in request/grant vectors matches the value.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_RF  = 1'b1
  } src_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bus bundle between the scheduler, its two data sources and the UART.
//
// Handshake rules:
//   ALU_VLD/ALU_RDY and RF_RD_VLD/RF_RDY are valid/ready pairs: a word moves on
//   a rising CLK edge where VLD and RDY are both high. VLD may rise without
//   waiting for RDY; RDY never depends combinationally on VLD. After a word
//   moves, RDY stays low until that word has fully left the transmitter.
//   TX_D_VLD is a one-cycle strobe with no ready; the transmitter pushes back
//   with TX_BUSY instead, and the scheduler never strobes while TX_BUSY is high
//   in IDLE.
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_VLD;
  logic                    ALU_RDY;
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_VLD;
  logic                    RF_RDY;
  logic                    TX_BUSY;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TMO_ERR;
  logic                    SCHED_BUSY;
  sched_state_e            DBG_STATE;

  // Environment side: sources, transmitter and observers.
  modport master (
    output ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    input  ALU_RDY, RF_RDY, TX_P_DATA, TX_D_VLD, TMO_ERR, SCHED_BUSY, DBG_STATE
  );

  // Scheduler side.
  modport slave (
    input  ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    output ALU_RDY, RF_RDY, TX_P_DATA, TX_D_VLD, TMO_ERR, SCHED_BUSY, DBG_STATE
  );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// source that was not granted last wins. Purely combinational: the caller
// owns the last-grant pointer and decides when it advances.
module rr_arb2
  import uart_tx_sched_pkg::*;
(
  input  logic [1:0] i_req,   // bit0 = ALU, bit1 = RF
  input  src_e       i_last,  // source granted by the most recent completed transfer
  output logic [1:0] o_gnt    // one-hot grant, same bit order as i_req
);

  // Grant selection: single requester passes straight through, tie alternates.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last == SRC_ALU) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers one ALU word (sent low byte then high
// byte) and one register-file byte, arbitrates between them round-robin and
// feeds the UART transmitter one byte at a time, watching TX_BUSY to pace
// itself. A byte whose strobe is not answered by TX_BUSY within TMO_CYCLES
// is flagged on TMO_ERR and strobed again.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input logic             CLK,
  input logic             RST,   // asynchronous, active low
  uart_tx_sched_if.slave  bus
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  // Holding buffers
  logic                    r_alu_pend;
  logic [2*DATA_WIDTH-1:0] r_alu_data;
  logic                    r_rf_pend;
  logic [DATA_WIDTH-1:0]   r_rf_data;

  // Scheduler state
  sched_state_e            r_state;
  sched_state_e            w_state_nxt;
  src_e                    r_sel;
  src_e                    w_sel_nxt;
  logic                    r_byte_idx;
  logic                    w_byte_idx_nxt;
  logic [TW-1:0]           r_tmo_cnt;
  logic [TW-1:0]           w_tmo_cnt_nxt;
  src_e                    r_last;
  logic [DATA_WIDTH-1:0]   r_tx_p_data;
  logic                    r_tmo_err;

  // Control strobes from the next-state logic
  logic                    w_load;      // present a new byte on TX_P_DATA
  logic                    w_done;      // granted transfer has fully completed
  logic                    w_tmo_fire;  // WAIT_HI ran out of patience
  logic                    w_alu_acc;
  logic                    w_rf_acc;
  logic [1:0]              w_gnt;
  logic [DATA_WIDTH-1:0]   w_byte;

  assign w_alu_acc = bus.ALU_VLD   & ~r_alu_pend;
  assign w_rf_acc  = bus.RF_RD_VLD & ~r_rf_pend;

  rr_arb2 u_arb (
    .i_req  ({r_rf_pend, r_alu_pend}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // Next-state and control decode for the scheduler FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_byte_idx_nxt = r_byte_idx;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_load         = 1'b0;
    w_done         = 1'b0;
    w_tmo_fire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A busy transmitter holds off the grant entirely.
        if ((r_alu_pend || r_rf_pend) && !bus.TX_BUSY) begin
          w_sel_nxt      = (w_gnt == 2'b10) ? SRC_RF : SRC_ALU;
          w_byte_idx_nxt = 1'b0;
          w_load         = 1'b1;
          w_state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_tmo_cnt_nxt = '0;
        w_state_nxt   = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.TX_BUSY) begin
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = ST_WAIT_LO;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // TX_P_DATA is left untouched so the retry carries the same byte.
          w_tmo_cnt_nxt = '0;
          w_tmo_fire    = 1'b1;
          w_state_nxt   = ST_ISSUE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.TX_BUSY) begin
          if (r_sel == SRC_ALU && !r_byte_idx) begin
            // High byte follows straight away, no trip through IDLE.
            w_byte_idx_nxt = 1'b1;
            w_load         = 1'b1;
            w_state_nxt    = ST_ISSUE;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte to load onto TX_P_DATA for the source/index about to be issued.
  always_comb begin
    w_byte = r_alu_data[DATA_WIDTH-1:0];
    if (w_sel_nxt == SRC_RF) begin
      w_byte = r_rf_data;
    end else if (w_byte_idx_nxt) begin
      w_byte = r_alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // FSM state register plus the transfer bookkeeping that moves with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_sel       <= SRC_ALU;
      r_byte_idx  <= 1'b0;
      r_tmo_cnt   <= '0;
      r_last      <= SRC_RF;
      r_tx_p_data <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_tmo_err  <= w_tmo_fire;
      if (w_load) begin
        r_tx_p_data <= w_byte;
      end
      if (w_done) begin
        r_last <= r_sel;
      end
    end
  end

  // ALU holding buffer: capture on accept, release only when the word is out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_pend <= 1'b0;
      r_alu_data <= '0;
    end else if (w_alu_acc) begin
      r_alu_pend <= 1'b1;
      r_alu_data <= bus.ALU_OUT;
    end else if (w_done && r_sel == SRC_ALU) begin
      r_alu_pend <= 1'b0;
    end
  end

  // RF holding buffer: capture on accept, release only when the byte is out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rf_pend <= 1'b0;
      r_rf_data <= '0;
    end else if (w_rf_acc) begin
      r_rf_pend <= 1'b1;
      r_rf_data <= bus.RF_RD_DATA;
    end else if (w_done && r_sel == SRC_RF) begin
      r_rf_pend <= 1'b0;
    end
  end

  assign bus.ALU_RDY    = ~r_alu_pend;
  assign bus.RF_RDY     = ~r_rf_pend;
  assign bus.TX_P_DATA  = r_tx_p_data;
  assign bus.TX_D_VLD   = (r_state == ST_ISSUE);
  assign bus.TMO_ERR    = r_tmo_err;
  assign bus.SCHED_BUSY = (r_state != ST_IDLE);
  assign bus.DBG_STATE  = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a table of transfer scenarios with hand-computed
// byte streams, followed by hand-written sequences for RDY timing, timeout
// retry, reset mid-transfer and transmitter back-pressure in IDLE.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int DW        = 8;
  localparam int MODE_RUN  = 0;  // transmitter answers each strobe: busy 1 cycle later for 10 cycles
  localparam int MODE_LOW  = 1;  // transmitter ignores strobes, busy held low
  localparam int MODE_HIGH = 2;  // transmitter stuck busy
  localparam logic [31:0] OUT_RST = {19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  uart_tx_sched_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_sched #(.DATA_WIDTH(DW), .TMO_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_pass    = 0;
  int          n_total   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int          vt_q[$];
  int          tmo_seen  = 0;
  bit          dbl_vld   = 1'b0;
  int          busy_mode = MODE_RUN;

  // ---------------- transmitter model ----------------
  initial begin : tx_model
    bit arm;
    int busy_cnt;
    arm      = 1'b0;
    busy_cnt = 0;
    bus.TX_BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (busy_mode)
        MODE_HIGH: begin bus.TX_BUSY = 1'b1; busy_cnt = 0; end
        MODE_LOW:  begin bus.TX_BUSY = 1'b0; busy_cnt = 0; end
        default: begin
          if (arm) begin
            arm = 1'b0;
            bus.TX_BUSY = 1'b1;
            busy_cnt = 10;
          end else if (busy_cnt > 0) begin
            busy_cnt--;
            bus.TX_BUSY = (busy_cnt != 0);
          end else begin
            bus.TX_BUSY = 1'b0;
          end
        end
      endcase
      if (bus.TX_D_VLD) arm = 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.TX_D_VLD) begin
        got_q.push_back(bus.TX_P_DATA);
        vt_q.push_back(cyc);
        if (prev) dbl_vld = 1'b1;
      end
      prev = bus.TX_D_VLD;
      if (bus.TMO_ERR) tmo_seen++;
    end
  end

  // ---------------- driver / checker tasks ----------------
  function automatic logic [31:0] outs();
    return {19'd0, bus.SCHED_BUSY, bus.ALU_RDY, bus.RF_RDY,
            bus.TX_D_VLD, bus.TMO_ERR, bus.TX_P_DATA};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    vt_q.delete();
    tmo_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    busy_mode = MODE_RUN;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Presents requests for one cycle; returns just after the accepting edge.
  task automatic send(input bit a_en, input logic [2*DW-1:0] a,
                      input bit r_en, input logic [DW-1:0] r);
    @(negedge CLK);
    bus.ALU_VLD    = a_en;
    bus.ALU_OUT    = a;
    bus.RF_RD_VLD  = r_en;
    bus.RF_RD_DATA = r;
    @(posedge CLK);
    #1;
    bus.ALU_VLD   = 1'b0;
    bus.RF_RD_VLD = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge CLK);
      if (!bus.SCHED_BUSY && bus.ALU_RDY && bus.RF_RDY && !bus.TX_BUSY) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    bit            do_rst;
    bit            a_en;
    logic [15:0]   a;
    bit            r_en;
    logic [7:0]    r;
    int            n;
    logic [7:0]    e0;
    logic [7:0]    e1;
    logic [7:0]    e2;
    int            gap;   // cycles between first and second strobe, 0 = not checked
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    bus.ALU_VLD    = 1'b0;
    bus.ALU_OUT    = '0;
    bus.RF_RD_VLD  = 1'b0;
    bus.RF_RD_DATA = '0;

    // RF alone; ALU alone; both from reset (ALU wins first tie); ALU alone so
    // ALU is last granted; both again (RF wins); both again (RF wins again).
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 8'hA5, 1, 8'hA5, 8'h00, 8'h00, 0};
    tbl[1] = '{1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 2, 8'h34, 8'h12, 8'h00, 12};
    tbl[2] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 8'h5A, 3, 8'hEF, 8'hBE, 8'h5A, 12};
    tbl[3] = '{1'b0, 1'b1, 16'h7788, 1'b0, 8'h00, 2, 8'h88, 8'h77, 8'h00, 12};
    tbl[4] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 8'h5A, 3, 8'h5A, 8'hEF, 8'hBE, 13};
    tbl[5] = '{1'b0, 1'b1, 16'h00FF, 1'b1, 8'h00, 3, 8'h00, 8'hFF, 8'h00, 13};

    // Reset values while RST is held low.
    repeat (2) @(negedge CLK);
    check("reset_outputs", outs(), OUT_RST);
    check("reset_state", 32'(bus.DBG_STATE), 32'(ST_IDLE));
    RST = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].do_rst) do_reset();
      clear_sb();
      exp_q.push_back(tbl[i].e0);
      if (tbl[i].n > 1) exp_q.push_back(tbl[i].e1);
      if (tbl[i].n > 2) exp_q.push_back(tbl[i].e2);
      send(tbl[i].a_en, tbl[i].a, tbl[i].r_en, tbl[i].r);
      wait_done($sformatf("vec%0d_done", i));
      compare_stream($sformatf("vec%0d", i));
      if (tbl[i].gap != 0)
        check($sformatf("vec%0d_gap", i),
              (vt_q.size() >= 2) ? 32'(vt_q[1] - vt_q[0]) : 32'hFFFF_FFFF,
              32'(tbl[i].gap));
    end

    // RF_RDY stays low from acceptance until the cycle after TX_BUSY falls.
    begin
      bit bad;
      do_reset();
      clear_sb();
      send(1'b0, 16'h0000, 1'b1, 8'hC3);
      bad = 1'b0;
      for (int k = 1; k <= 13; k++) begin
        @(negedge CLK);
        if (bus.RF_RDY) bad = 1'b1;
        if (k == 2) check("rf_issue_slot", {23'd0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'd0, 1'b1, 8'hC3});
      end
      check("rf_rdy_low_in_flight", 32'(bad), 32'd0);
      @(negedge CLK);
      check("rf_rdy_after_busy_fall", 32'(bus.RF_RDY), 32'd1);
      wait_done("rf_seq_done");
    end

    // No TX_BUSY answer: four WAIT_HI cycles, then TMO_ERR with a reissue.
    do_reset();
    clear_sb();
    busy_mode = MODE_LOW;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    send(1'b0, 16'h0000, 1'b1, 8'h3C);
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      if (k == 6) check("tmo_not_early", 32'(bus.TMO_ERR), 32'd0);
    end
    check("tmo_pulse_with_reissue",
          {22'd0, bus.TMO_ERR, bus.TX_D_VLD, bus.TX_P_DATA}, {22'd0, 1'b1, 1'b1, 8'h3C});
    busy_mode = MODE_RUN;
    @(negedge CLK);
    check("tmo_one_cycle", 32'(bus.TMO_ERR), 32'd0);
    wait_done("tmo_done");
    compare_stream("tmo");
    check("tmo_count", 32'(tmo_seen), 32'd1);

    // Reset during WAIT_LO of ALU byte 0: immediate reset outputs, no high byte.
    do_reset();
    clear_sb();
    exp_q.push_back(8'hCD);
    send(1'b1, 16'hABCD, 1'b0, 8'h00);
    repeat (5) @(negedge CLK);
    check("rst_pre_state", 32'(bus.DBG_STATE), 32'(ST_WAIT_LO));
    #1;
    RST = 1'b0;
    #1;
    check("rst_async_outputs", outs(), OUT_RST);
    check("rst_async_state", 32'(bus.DBG_STATE), 32'(ST_IDLE));
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    compare_stream("rst_mid");
    check("rst_mid_idle", 32'(bus.SCHED_BUSY), 32'd0);

    // Transmitter busy while a request waits in IDLE: no strobe until it clears.
    do_reset();
    clear_sb();
    busy_mode = MODE_HIGH;
    exp_q.push_back(8'h77);
    send(1'b0, 16'h0000, 1'b1, 8'h77);
    repeat (6) @(negedge CLK);
    check("busy_hold_no_vld", 32'(got_q.size()), 32'd0);
    check("busy_hold_state", {30'd0, bus.SCHED_BUSY, bus.RF_RDY}, 32'd0);
    busy_mode = MODE_RUN;
    wait_done("busy_hold_done");
    compare_stream("busy_hold");

    check("no_back_to_back_vld", 32'(dbl_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
